// File: rtl/btn_pkg.sv
// Shared definitions for the push-button gesture classifier: state encoding,
// the gesture event type used by downstream UI FSMs, and a sizing helper.
package btn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_HELD   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_PRESS1 = ST_PRESS1,
    S_WAIT2  = ST_WAIT2,
    S_PRESS2 = ST_PRESS2,
    S_HELD   = ST_HELD
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_SHORT  = 3'd1,
    EV_LONG   = 3'd2,
    EV_DOUBLE = 3'd3,
    EV_REPEAT = 3'd4
  } event_e;

  // Largest of three thresholds; sizes the shared gesture counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_classifier_gesture_timer.sv
// Gesture timer: clearable, enabled up-counter with a terminal compare
// against the threshold of whichever state is currently timing.
module gesture_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_val_i,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment; idle states hold the value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owning FSM always leaves the state (or clears) on the terminal
  // cycle, so the counter never runs past the threshold and never wraps.
  assign term_o = en_i && (cnt_q == term_val_i);

endmodule

// File: rtl/button_press_classifier.sv
// Push-button gesture classifier: turns a debounced, clk-synchronous button
// level into one-cycle short / long / double (and optional repeat) events.
// Optional feature: define AUTO_REPEAT_EN to emit repeat_pulse every
// REPEAT_CYCLES while the button stays held after a long press.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int DCLICK_CYCLES = 30_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int CNT_W = $clog2(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES));

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_e           state_q;
  state_e           state_d;
  event_e           ev_d;
  logic             btn_prev_q;
  logic             short_q;
  logic             long_q;
  logic             double_q;
  logic             busy_q;
  logic             rise;
  logic             fall;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_term;
  logic [CNT_W-1:0] term_val;

  assign rise = btn_in & ~btn_prev_q;
  assign fall = ~btn_in & btn_prev_q;

  // Timer enable and threshold depend only on the current state, which keeps
  // the terminal flag free of any combinational loop through the FSM.
  always_comb begin
    tmr_en   = 1'b0;
    term_val = '0;
    case (state_q)
      S_PRESS1: begin
        tmr_en   = 1'b1;
        term_val = LONG_TERM;
      end
      S_WAIT2: begin
        tmr_en   = 1'b1;
        term_val = DCLICK_TERM;
      end
`ifdef AUTO_REPEAT_EN
      S_HELD: begin
        tmr_en   = 1'b1;
        term_val = REPEAT_TERM;
      end
`endif
      default: begin
        tmr_en   = 1'b0;
        term_val = '0;
      end
    endcase
  end

  // Next state and gesture event; edges take priority over timeouts.
  always_comb begin
    state_d = state_q;
    ev_d    = EV_NONE;
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (fall) begin
          state_d = S_WAIT2;
        end else if (tmr_term) begin
          state_d = S_HELD;
          ev_d    = EV_LONG;
        end
      end
      S_WAIT2: begin
        if (rise) begin
          state_d = S_PRESS2;
        end else if (tmr_term) begin
          state_d = S_IDLE;
          ev_d    = EV_SHORT;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          state_d = S_IDLE;
          ev_d    = EV_DOUBLE;
        end
      end
      S_HELD: begin
`ifdef AUTO_REPEAT_EN
        if (fall) begin
          state_d = S_IDLE;
        end else if (tmr_term) begin
          ev_d = EV_REPEAT;
        end
`else
        if (fall) state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter restarts on every state change and after each auto-repeat.
  assign tmr_clr = (state_d != state_q) || (ev_d == EV_REPEAT);

  gesture_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (tmr_clr),
    .en_i       (tmr_en),
    .term_val_i (term_val),
    .term_o     (tmr_term)
  );

`ifdef AUTO_REPEAT_EN
  logic repeat_q;
`endif

  // FSM state, edge history and registered one-cycle event outputs. The
  // edge history loads the live level in reset so a button held through
  // reset produces no rise until it has been released.
  always_ff @(posedge clk) begin
    btn_prev_q <= btn_in;
    if (reset) begin
      state_q  <= S_IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      short_q  <= (ev_d == EV_SHORT);
      long_q   <= (ev_d == EV_LONG);
      double_q <= (ev_d == EV_DOUBLE);
      busy_q   <= (state_d != S_IDLE);
`ifdef AUTO_REPEAT_EN
      repeat_q <= (ev_d == EV_REPEAT);
`endif
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = double_q;
  assign busy         = busy_q;
`ifdef AUTO_REPEAT_EN
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with short thresholds
// (LONG=20, DCLICK=10, REPEAT=5). Honours AUTO_REPEAT_EN when defined.
module tb_button_press_classifier;

  localparam int LONG   = 20;
  localparam int DCLICK = 10;
  localparam int REPEAT = 5;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic short_pulse, long_pulse, double_pulse, repeat_pulse, busy;

  button_press_classifier #(
    .LONG_CYCLES   (LONG),
    .DCLICK_CYCLES (DCLICK),
    .REPEAT_CYCLES (REPEAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .double_pulse (double_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, last-seen cycle, overlap and width violations.
  int n_short = 0, n_long = 0, n_double = 0, n_repeat = 0;
  int t_short = 0, t_long = 0, t_double = 0, t_repeat = 0;
  int n_multi = 0, n_wide = 0;
  logic p_s = 1'b0, p_l = 1'b0, p_d = 1'b0, p_r = 1'b0;

  always @(negedge clk) begin
    if (short_pulse === 1'b1)  begin n_short  <= n_short + 1;  t_short  <= cyc; end
    if (long_pulse === 1'b1)   begin n_long   <= n_long + 1;   t_long   <= cyc; end
    if (double_pulse === 1'b1) begin n_double <= n_double + 1; t_double <= cyc; end
    if (repeat_pulse === 1'b1) begin n_repeat <= n_repeat + 1; t_repeat <= cyc; end
    if ($countones({short_pulse === 1'b1, long_pulse === 1'b1,
                    double_pulse === 1'b1, repeat_pulse === 1'b1}) > 1)
      n_multi <= n_multi + 1;
    if ((short_pulse === 1'b1 && p_s) || (long_pulse === 1'b1 && p_l) ||
        (double_pulse === 1'b1 && p_d) || (repeat_pulse === 1'b1 && p_r))
      n_wide <= n_wide + 1;
    p_s <= (short_pulse === 1'b1);
    p_l <= (long_pulse === 1'b1);
    p_d <= (double_pulse === 1'b1);
    p_r <= (repeat_pulse === 1'b1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_short, b_long, b_double, b_repeat;
  task automatic snap();
    b_short  = n_short;
    b_long   = n_long;
    b_double = n_double;
    b_repeat = n_repeat;
  endtask

  int t0, r;

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    tick(3);
    check("rst_short",  short_pulse,  0);
    check("rst_long",   long_pulse,   0);
    check("rst_double", double_pulse, 0);
    check("rst_repeat", repeat_pulse, 0);
    check("rst_busy",   busy,         0);
    reset = 1'b0;
    tick(2);

    // 1: short press
    snap(); t0 = cyc; btn_in = 1'b1;
    tick(1);
    check("s1_busy_press", busy, 1);
    tick(4); r = cyc; btn_in = 1'b0;
    tick(15);
    check("s1_short_cnt",  n_short - b_short, 1);
    check("s1_short_time", t_short - r, DCLICK + 1);
    check("s1_long_cnt",   n_long - b_long, 0);
    check("s1_double_cnt", n_double - b_double, 0);
    check("s1_busy_end",   busy, 0);

    // 2: long press, held 27 cycles
    snap(); t0 = cyc; btn_in = 1'b1;
    tick(10);
    check("s2_busy_held", busy, 1);
    tick(17); btn_in = 1'b0;
    tick(15);
    check("s2_long_cnt",  n_long - b_long, 1);
    check("s2_long_time", t_long - t0, LONG + 1);
`ifdef AUTO_REPEAT_EN
    check("s2_repeat_cnt",  n_repeat - b_repeat, 1);
    check("s2_repeat_time", t_repeat - t0, LONG + REPEAT + 1);
`else
    check("s2_repeat_cnt",  n_repeat - b_repeat, 0);
`endif
    check("s2_short_cnt", n_short - b_short, 0);
    check("s2_busy_end",  busy, 0);

    // 3: double press, gap 3
    snap(); btn_in = 1'b1;
    tick(4); btn_in = 1'b0;
    tick(3); btn_in = 1'b1;
    tick(4); r = cyc; btn_in = 1'b0;
    tick(15);
    check("s3_double_cnt",  n_double - b_double, 1);
    check("s3_double_time", t_double - r, 1);
    check("s3_short_cnt",   n_short - b_short, 0);
    check("s3_long_cnt",    n_long - b_long, 0);

    // 4: gap exactly DCLICK, rise lands on the terminal cycle
    snap(); btn_in = 1'b1;
    tick(4); btn_in = 1'b0;
    tick(DCLICK); btn_in = 1'b1;
    tick(4); r = cyc; btn_in = 1'b0;
    tick(15);
    check("s4_double_cnt",  n_double - b_double, 1);
    check("s4_double_time", t_double - r, 1);
    check("s4_short_cnt",   n_short - b_short, 0);

    // 5a: reset while waiting for a second press
    snap(); btn_in = 1'b1;
    tick(4); btn_in = 1'b0;
    tick(3); reset = 1'b1;
    tick(2); reset = 1'b0;
    tick(15);
    check("s5a_pulses", (n_short - b_short) + (n_long - b_long) +
                        (n_double - b_double) + (n_repeat - b_repeat), 0);
    check("s5a_busy", busy, 0);

    // 5b: reset while held after long press, button kept down through reset
    btn_in = 1'b1;
    tick(23);
    snap(); reset = 1'b1;
    tick(2); reset = 1'b0;
    tick(30);
    check("s5b_pulses", (n_short - b_short) + (n_long - b_long) +
                        (n_double - b_double) + (n_repeat - b_repeat), 0);
    check("s5b_busy", busy, 0);
    btn_in = 1'b0;
    tick(3);
    snap(); btn_in = 1'b1;
    tick(5); r = cyc; btn_in = 1'b0;
    tick(15);
    check("s5b_short_cnt",  n_short - b_short, 1);
    check("s5b_short_time", t_short - r, DCLICK + 1);
    check("s5b_long_cnt",   n_long - b_long, 0);

    // 6: release sampled on the long terminal cycle
    snap(); btn_in = 1'b1;
    tick(LONG); r = cyc; btn_in = 1'b0;
    tick(15);
    check("s6_long_cnt",   n_long - b_long, 0);
    check("s6_short_cnt",  n_short - b_short, 1);
    check("s6_short_time", t_short - r, DCLICK + 1);

    check("pulse_overlap", n_multi, 0);
    check("pulse_width",   n_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
